// File: rtl/writeback_if.sv
// Bundle of the writeback unit's handshake and register-file signals.
// master: the writeback unit itself; slave: the surrounding pipeline.
interface writeback_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_resp_valid;
  logic        ld_resp_ready;
  logic [4:0]  ld_resp_rd;
  logic [31:0] ld_resp_data;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] din;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rf_r1;
  logic [31:0] rf_r2;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy1;
  logic        busy2;

  modport master (
    input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
    input  ld_resp_valid, ld_resp_rd, ld_resp_data, rs1, rs2, rf_r1, rf_r2,
    output alu_stall, ld_resp_ready, wen, rd, din, op1, op2, busy1, busy2
  );

  modport slave (
    output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
    output ld_resp_valid, ld_resp_rd, ld_resp_data, rs1, rs2, rf_r1, rf_r2,
    input  alu_stall, ld_resp_ready, wen, rd, din, op1, op2, busy1, busy2
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: merges ALU results and buffered load responses into a
// single register-file write port, and tracks registers with loads in flight.
// Optional build macro WB_BYPASS_EN forwards the registered write into op1/op2.
module writeback_unit (
  input logic         clk,
  input logic         rst,
  writeback_if.master bus
);

  // Load response buffer: two {rd, data} entries with explicit occupancy.
  logic [1:0][36:0] fifo_q, fifo_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             fifo_full, fifo_empty, push, pop;

  // Registered write port and its origin.
  logic        wen_q, wen_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] din_q, din_d;
  logic        from_fifo_q, from_fifo_d;

  // One bit per architectural register with a load still outstanding.
  logic [31:0] busy_q, busy_d;

  // Buffer bookkeeping; ready depends only on current occupancy, never on pop.
  always_comb begin
    fifo_full  = (count_q == 2'd2);
    fifo_empty = (count_q == 2'd0);
    push       = bus.ld_resp_valid && !fifo_full;
    fifo_d     = fifo_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (push) begin
      fifo_d[tail_q] = {bus.ld_resp_rd, bus.ld_resp_data};
      tail_d         = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Write arbitration: ALU has priority, otherwise drain the buffer head.
  always_comb begin
    wen_d       = 1'b0;
    rd_d        = rd_q;
    din_d       = din_q;
    from_fifo_d = 1'b0;
    pop         = 1'b0;
    if (bus.alu_valid) begin
      wen_d = (bus.alu_rd != 5'd0);
      rd_d  = bus.alu_rd;
      din_d = bus.alu_data;
    end else if (!fifo_empty) begin
      pop         = 1'b1;
      from_fifo_d = 1'b1;
      rd_d        = fifo_q[head_q][36:32];
      din_d       = fifo_q[head_q][31:0];
      wen_d       = (fifo_q[head_q][36:32] != 5'd0);
    end
  end

  // Scoreboard update; a new issue overrides a retiring load to the same register.
  always_comb begin
    busy_d = busy_q;
    if (wen_q && from_fifo_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (bus.ld_issue && (bus.ld_issue_rd != 5'd0)) begin
      busy_d[bus.ld_issue_rd] = 1'b1;
    end
  end

  // State registers; reset drops buffered responses and all pending loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q      <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      count_q     <= 2'd0;
      wen_q       <= 1'b0;
      rd_q        <= 5'd0;
      din_q       <= 32'd0;
      from_fifo_q <= 1'b0;
      busy_q      <= 32'd0;
    end else begin
      fifo_q      <= fifo_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      wen_q       <= wen_d;
      rd_q        <= rd_d;
      din_q       <= din_d;
      from_fifo_q <= from_fifo_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.alu_stall     = fifo_full;
  assign bus.ld_resp_ready = !fifo_full;
  assign bus.wen           = wen_q;
  assign bus.rd            = rd_q;
  assign bus.din           = din_q;
  assign bus.busy1         = busy_q[bus.rs1];
  assign bus.busy2         = busy_q[bus.rs2];

`ifdef WB_BYPASS_EN
  // Forward the write currently on the port to readers of the same register.
  always_comb begin
    bus.op1 = bus.rf_r1;
    bus.op2 = bus.rf_r2;
    if (wen_q && (rd_q == bus.rs1) && (rd_q != 5'd0)) begin
      bus.op1 = din_q;
    end
    if (wen_q && (rd_q == bus.rs2) && (rd_q != 5'd0)) begin
      bus.op2 = din_q;
    end
  end
`else
  assign bus.op1 = bus.rf_r1;
  assign bus.op2 = bus.rf_r2;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: directed scenarios followed by random traffic,
// all compared against a queue-based behavioural model of the unit.
module tb_writeback_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_if bus ();

  writeback_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [36:0] m_fifo[$];
  logic [31:0] m_busy;
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_din;
  logic        m_from;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    m_fifo.delete();
    m_busy = 32'd0;
    m_wen  = 1'b0;
    m_rd   = 5'd0;
    m_din  = 32'd0;
    m_from = 1'b0;
  endtask

  task automatic idleStrobes();
    bus.alu_valid     = 1'b0;
    bus.alu_rd        = 5'd0;
    bus.alu_data      = 32'd0;
    bus.ld_issue      = 1'b0;
    bus.ld_issue_rd   = 5'd0;
    bus.ld_resp_valid = 1'b0;
    bus.ld_resp_rd    = 5'd0;
    bus.ld_resp_data  = 32'd0;
  endtask

  // Compare every output against the model's view of the current cycle
  task automatic checkOutput();
    logic [31:0] e_op1, e_op2;
`ifdef WB_BYPASS_EN
    e_op1 = (m_wen && m_rd == bus.rs1 && m_rd != 5'd0) ? m_din : bus.rf_r1;
    e_op2 = (m_wen && m_rd == bus.rs2 && m_rd != 5'd0) ? m_din : bus.rf_r2;
`else
    e_op1 = bus.rf_r1;
    e_op2 = bus.rf_r2;
`endif
    chk("wen", 32'(bus.wen), 32'(m_wen));
    if (m_wen) begin
      chk("rd", 32'(bus.rd), 32'(m_rd));
      chk("din", bus.din, m_din);
    end
    chk("ld_resp_ready", 32'(bus.ld_resp_ready), 32'(m_fifo.size() < 2));
    chk("alu_stall", 32'(bus.alu_stall), 32'(m_fifo.size() == 2));
    chk("busy1", 32'(bus.busy1), 32'(m_busy[bus.rs1]));
    chk("busy2", 32'(bus.busy2), 32'(m_busy[bus.rs2]));
    chk("op1", bus.op1, e_op1);
    chk("op2", bus.op2, e_op2);
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic modelStep();
    logic        sel, from, can_push;
    logic [4:0]  srd;
    logic [31:0] sdat;
    logic [36:0] e;
    can_push = (m_fifo.size() < 2);
    sel = 1'b0; from = 1'b0; srd = 5'd0; sdat = 32'd0;
    if (bus.alu_valid) begin
      sel = 1'b1; srd = bus.alu_rd; sdat = bus.alu_data;
    end else if (m_fifo.size() > 0) begin
      e = m_fifo.pop_front();
      sel = 1'b1; from = 1'b1; srd = e[36:32]; sdat = e[31:0];
    end
    if (bus.ld_resp_valid && can_push) m_fifo.push_back({bus.ld_resp_rd, bus.ld_resp_data});
    if (m_wen && m_from) m_busy[m_rd] = 1'b0;
    if (bus.ld_issue && bus.ld_issue_rd != 5'd0) m_busy[bus.ld_issue_rd] = 1'b1;
    m_wen  = sel && (srd != 5'd0);
    m_from = from;
    if (sel) begin
      m_rd  = srd;
      m_din = sdat;
    end
  endtask

  // One cycle: settle, check, model the edge, and return at the next negedge
  task automatic applyStimulus();
    #1;
    checkOutput();
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idleStrobes();
    bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.rf_r1 = 32'd0; bus.rf_r2 = 32'd0;
    resetModel();

    // Reset state
    @(negedge clk); @(negedge clk);
    bus.rs1 = 5'd4; bus.rs2 = 5'd31;
    #1;
    chk("rst_wen", 32'(bus.wen), 32'd0);
    chk("rst_rd", 32'(bus.rd), 32'd0);
    chk("rst_din", bus.din, 32'd0);
    chk("rst_ready", 32'(bus.ld_resp_ready), 32'd1);
    chk("rst_stall", 32'(bus.alu_stall), 32'd0);
    chk("rst_busy1", 32'(bus.busy1), 32'd0);
    chk("rst_busy2", 32'(bus.busy2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus();
    chk("post_rst_wen", 32'(bus.wen), 32'd0);

    // ALU path
    $display("[TB] ALU path");
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    applyStimulus();
    idleStrobes();
    #1;
    chk("alu_wen", 32'(bus.wen), 32'd1);
    chk("alu_rd", 32'(bus.rd), 32'd5);
    chk("alu_din", bus.din, 32'hDEADBEEF);
    applyStimulus();
    chk("alu_idle_wen", 32'(bus.wen), 32'd0);

    // Contention between ALU and load responses
    $display("[TB] contention");
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
    applyStimulus();
    bus.alu_rd = 5'd2; bus.alu_data = 32'h2;
    bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd7; bus.ld_resp_data = 32'h11;
    applyStimulus();
    bus.alu_rd = 5'd6; bus.alu_data = 32'h6;
    bus.ld_resp_rd = 5'd8; bus.ld_resp_data = 32'h22;
    applyStimulus();
    idleStrobes();
    #1;
    chk("full_stall", 32'(bus.alu_stall), 32'd1);
    chk("full_ready", 32'(bus.ld_resp_ready), 32'd0);
    bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd9; bus.ld_resp_data = 32'h99;
    applyStimulus();
    idleStrobes();
    #1;
    chk("drain1_wen", 32'(bus.wen), 32'd1);
    chk("drain1_rd", 32'(bus.rd), 32'd7);
    chk("drain1_din", bus.din, 32'h11);
    chk("drain1_ready", 32'(bus.ld_resp_ready), 32'd1);
    applyStimulus();
    chk("drain2_rd", 32'(bus.rd), 32'd8);
    chk("drain2_din", bus.din, 32'h22);
    applyStimulus();
    chk("drain_done_wen", 32'(bus.wen), 32'd0);

    // Scoreboard
    $display("[TB] scoreboard");
    bus.rs1 = 5'd3;
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd3;
    applyStimulus();
    idleStrobes();
    #1;
    chk("sb_set", 32'(bus.busy1), 32'd1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h77;
    applyStimulus();
    idleStrobes();
    bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd3; bus.ld_resp_data = 32'h33;
    applyStimulus();
    idleStrobes();
    #1;
    chk("sb_alu_keep", 32'(bus.busy1), 32'd1);
    applyStimulus();
    chk("sb_wr_rd", 32'(bus.rd), 32'd3);
    chk("sb_during_wr", 32'(bus.busy1), 32'd1);
    applyStimulus();
    chk("sb_cleared", 32'(bus.busy1), 32'd0);

    // Register zero
    $display("[TB] x0");
    bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd0; bus.ld_resp_data = 32'hFFFFFFFF;
    applyStimulus();
    idleStrobes();
    applyStimulus();
    chk("x0_wen", 32'(bus.wen), 32'd0);
    chk("x0_ready", 32'(bus.ld_resp_ready), 32'd1);
    bus.rs1 = 5'd0;
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd0;
    applyStimulus();
    idleStrobes();
    #1;
    chk("x0_busy", 32'(bus.busy1), 32'd0);

    // Operand bypass
    $display("[TB] bypass");
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'hA5A5A5A5;
    applyStimulus();
    idleStrobes();
    bus.rs2 = 5'd9; bus.rf_r2 = 32'd0;
    #1;
`ifdef WB_BYPASS_EN
    chk("bypass_op2", bus.op2, 32'hA5A5A5A5);
`else
    chk("bypass_op2", bus.op2, 32'd0);
`endif
    applyStimulus();

    // Random traffic
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      bus.alu_valid     = (m_fifo.size() < 2) && ($urandom_range(0, 2) == 0);
      bus.alu_rd        = 5'($urandom_range(0, 7));
      bus.alu_data      = $urandom;
      bus.ld_issue      = ($urandom_range(0, 2) == 0);
      bus.ld_issue_rd   = 5'($urandom_range(0, 7));
      bus.ld_resp_valid = ($urandom_range(0, 1) == 0);
      bus.ld_resp_rd    = 5'($urandom_range(0, 7));
      bus.ld_resp_data  = $urandom;
      bus.rs1           = 5'($urandom_range(0, 7));
      bus.rs2           = 5'($urandom_range(0, 7));
      bus.rf_r1         = $urandom;
      bus.rf_r2         = $urandom;
      applyStimulus();
    end
    idleStrobes();
    for (int i = 0; i < 4; i++) applyStimulus();

    // Reset mid-operation
    $display("[TB] reset mid-operation");
    bus.rs1 = 5'd4;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
    bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd10; bus.ld_resp_data = 32'hAAAA;
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd4;
    applyStimulus();
    bus.ld_issue = 1'b0;
    bus.alu_rd = 5'd2; bus.alu_data = 32'h2;
    bus.ld_resp_rd = 5'd11; bus.ld_resp_data = 32'hBBBB;
    applyStimulus();
    idleStrobes();
    #1;
    chk("pre_rst_stall", 32'(bus.alu_stall), 32'd1);
    chk("pre_rst_busy", 32'(bus.busy1), 32'd1);
    rst = 1'b1;
    resetModel();
    #1;
    chk("mid_rst_wen", 32'(bus.wen), 32'd0);
    chk("mid_rst_ready", 32'(bus.ld_resp_ready), 32'd1);
    chk("mid_rst_stall", 32'(bus.alu_stall), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy1), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      chk("post_rst_nowrite", 32'(bus.wen), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports, one per line (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_stall  out  1  upstream SHALL NOT assert alu_valid while high
- ld_issue  in  1  load issued this cycle
- ld_issue_rd  in  5  load destination register
- ld_resp_valid  in  1  load response offered
- ld_resp_ready  out  1  response accepted when valid and ready are both high
- ld_resp_rd  in  5  load response destination
- ld_resp_data  in  32  load response data
- wen  out  1  register-file write enable
- rd  out  5  register-file write address
- din  out  32  register-file write data
- rs1, rs2  in  5 each  register-file read addresses
- rf_r1, rf_r2  in  32 each  register-file read data
- op1, op2  out  32 each  operand data to execute stage
- busy1, busy2  out  1 each  rs1/rs2 has a pending load

Function
REQ-003 SHALL buffer accepted load responses in a 2-entry FIFO, as {rd, data}, in arrival order.
REQ-004 ld_resp_ready SHALL equal "FIFO not full"; an accepted response SHALL be written at the tail on the same clock edge.
REQ-005 Arbitration each cycle SHALL work as follows:
- alu_valid high: select the ALU result.
- else FIFO non-empty: select and pop the FIFO head.
- else: select nothing.
REQ-006 The selected write SHALL be registered into wen/rd/din on the next rising edge, giving a write-port latency of 1 cycle. With no selection, wen SHALL be 0; rd and din SHALL hold their values.
REQ-007 A selected write with destination 0 SHALL produce wen=0. A FIFO entry selected this way SHALL still be popped.
REQ-008 alu_stall SHALL equal "FIFO full". While alu_stall is high, the FIFO head SHALL drain at one entry per cycle.
REQ-009 Push and pop in the same cycle SHALL leave the occupancy unchanged. When the FIFO is full and a pop occurs, ld_resp_ready SHALL remain 0 for that cycle (ready is not combinationally dependent on pop).
REQ-010 The SHALL keep a 32-bit busy scoreboard:
- ld_issue sets busy[ld_issue_rd]; bit 0 is never set.
- A registered write with wen=1 that originated from the FIFO clears busy[rd].
REQ-011 If a set and a clear target the same register in the same cycle, the set SHALL win. ALU writes SHALL NOT clear busy bits.
REQ-012 busy1 SHALL equal busy[rs1] and busy2 SHALL equal busy[rs2], combinationally.
REQ-013 FIFO pointers SHALL wrap modulo 2 using an explicit occupancy count (0..2).

Reset
REQ-014 While rst is high, all of the following SHALL hold (asynchronous assertion, deassertion sampled at clk):
- wen=0, rd=0, din=0.
- FIFO empty, so ld_resp_ready=1 and alu_stall=0.
- All busy bits 0.
REQ-015 Reset asserted mid-operation SHALL discard buffered responses and pending-load state. No write SHALL occur on the cycle following reset deassertion.

Configuration
REQ-016 Macro WB_BYPASS_EN defined:
- op1 = din when wen=1, rd=rs1 and rd≠0; otherwise op1 = rf_r1.
- op2 behaves identically with rs2 and rf_r2.
REQ-017 Macro WB_BYPASS_EN undefined: op1=rf_r1 and op2=rf_r2 unconditionally. All ports SHALL be present in both builds.

Verification
REQ-018 ALU path: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at cycle N -> wen=1, rd=5, din=0xDEADBEEF in cycle N+1; wen=0 in N+2 if idle.
REQ-019 Contention: alu_valid held for 3 cycles while two loads are accepted (rd=7 data=0x11, then rd=8 data=0x22):
- alu_stall=1 once the FIFO is full.
- After alu_valid drops, writes rd=7/0x11 then rd=8/0x22 occur on consecutive cycles.
- ld_resp_ready returns to 1.
REQ-020 Scoreboard: ld_issue rd=3, then rs1=3 -> busy1=1 until the cycle after the write of rd=3 from the FIFO, then 0. An ALU write to 3 in between leaves busy1=1.
REQ-021 x0: load response rd=0 data=0xFFFFFFFF -> FIFO pops, wen stays 0, no busy change. ld_issue rd=0 -> busy1=0 with rs1=0.
REQ-022 Bypass (WB_BYPASS_EN defined): wen=1, rd=9, din=0xA5A5A5A5, rs2=9, rf_r2=0 -> op2=0xA5A5A5A5. Same stimulus without the macro -> op2=0.
REQ-023 Reset mid-operation: FIFO holding 2 entries plus busy[4]=1, rst pulsed -> wen=0, ld_resp_ready=1, alu_stall=0, busy=0, and no buffered entry is ever written.
